// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared types for the reset sequencer
// Sequencer state encoding and the shared interval timer width.
package reset_sequencer_pkg;

  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_e;

endpackage

// File: rtl/reset_sequencer_timer.sv
// rtl/reset_sequencer_timer.sv - 16-bit loadable down-counter
// Shared by the hold, gap and acknowledge-timeout intervals; load wins over decrement.
module reset_sequencer_timer
  import reset_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [TMR_W-1:0] o_count
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases stage resets one by one in ascending order
// Each stage waits for its acknowledge (or a timeout) before the next is released.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sw_rst_req,
  input  logic [NUM_STAGES-1:0] i_stage_ack,
  output logic [NUM_STAGES-1:0] o_out_rst_n,
  output logic                  o_all_ready,
  output logic                  o_timeout
);

  localparam int               IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [TMR_W-1:0] LP_HOLD   = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] LP_GAP    = TMR_W'(GAP_CYCLES);
  localparam logic [TMR_W-1:0] LP_ACK_TO = TMR_W'(ACK_TIMEOUT);
  localparam logic [IDX_W-1:0] LP_LAST   = IDX_W'(NUM_STAGES - 1);

  seq_state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt, w_idx_inc;
  logic [NUM_STAGES-1:0] r_out_rst_n, w_out_nxt;
  logic                  r_all_ready, w_ready_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic                  w_tmr_load, w_tmr_dec, w_tmr_hit, w_to_hit, w_ack;
  logic [TMR_W-1:0]      w_tmr_val, w_tmr_count;

  reset_sequencer_timer u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_count    (w_tmr_count)
  );

  // An interval ends on the edge where the count steps from 1 to 0.
  assign w_tmr_hit = (w_tmr_count == TMR_W'(1));
  assign w_to_hit  = (LP_ACK_TO != '0) && w_tmr_hit;
  assign w_ack     = i_stage_ack[r_idx];
  assign w_idx_inc = r_idx + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_out_nxt     = r_out_rst_n;
    w_ready_nxt   = r_all_ready;
    w_timeout_nxt = r_timeout;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_tmr_dec     = 1'b0;

    if (i_sw_rst_req) begin
      w_state_nxt   = ST_HOLD;
      w_idx_nxt     = '0;
      w_out_nxt     = '0;
      w_ready_nxt   = 1'b0;
      w_timeout_nxt = 1'b0;
      w_tmr_load    = 1'b1;
      w_tmr_val     = LP_HOLD;
    end else begin
      unique case (r_state)
        ST_HOLD: begin
          // A zero count here means hardware reset just ended: the first edge counts as one.
          if ((w_tmr_count == '0) && (LP_HOLD != TMR_W'(1))) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = LP_HOLD - 1'b1;
          end else if ((w_tmr_count == '0) || w_tmr_hit) begin
            w_out_nxt[0] = 1'b1;
            w_idx_nxt    = '0;
            w_state_nxt  = ST_WAIT_ACK;
            w_tmr_load   = 1'b1;
            w_tmr_val    = LP_ACK_TO;
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          w_tmr_dec = 1'b1;
          if (w_ack || w_to_hit) begin
            if (!w_ack) w_timeout_nxt = 1'b1;
            if (r_idx == LP_LAST) begin
              w_state_nxt = ST_DONE;
              w_ready_nxt = 1'b1;
            end else if (LP_GAP == '0) begin
              w_out_nxt[w_idx_inc] = 1'b1;
              w_idx_nxt            = w_idx_inc;
              w_tmr_load           = 1'b1;
              w_tmr_val            = LP_ACK_TO;
            end else begin
              w_state_nxt = ST_GAP;
              w_tmr_load  = 1'b1;
              w_tmr_val   = LP_GAP;
            end
          end
        end
        ST_GAP: begin
          w_tmr_dec = 1'b1;
          if (w_tmr_hit) begin
            w_out_nxt[w_idx_inc] = 1'b1;
            w_idx_nxt            = w_idx_inc;
            w_state_nxt          = ST_WAIT_ACK;
            w_tmr_load           = 1'b1;
            w_tmr_val            = LP_ACK_TO;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_HOLD;
      r_idx       <= '0;
      r_out_rst_n <= '0;
      r_all_ready <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_rst_n <= w_out_nxt;
      r_all_ready <= w_ready_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign o_out_rst_n = r_out_rst_n;
  assign o_all_ready = r_all_ready;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
// Three instances with different timing parameters share clock, reset and software request.
module tb_reset_sequencer;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw;
  logic [2:0] ack_a, ack_b, ack_c;
  logic [2:0] out_a, out_b, out_c;
  logic       rdy_a, rdy_b, rdy_c, to_a, to_b, to_c;

  int errors = 0;
  int checks = 0;

  int p_h[3] = '{4, 2, 4};
  int p_g[3] = '{2, 0, 2};
  int p_t[3] = '{0, 0, 5};

  // Reference model: release edges computed from elapsed edge counts.
  int m_e;
  int m_rel[3], m_pend[3], m_since[3];
  int m_rel_edge[3][3];
  bit m_wait[3], m_rdy[3], m_to[3];

  logic [2:0] d_out[3];
  logic       d_rdy[3], d_to[3];

  always_comb begin
    d_out[0] = out_a; d_out[1] = out_b; d_out[2] = out_c;
    d_rdy[0] = rdy_a; d_rdy[1] = rdy_b; d_rdy[2] = rdy_c;
    d_to[0]  = to_a;  d_to[1]  = to_b;  d_to[2]  = to_c;
  end

  reset_sequencer #(.NUM_STAGES(3), .HOLD_CYCLES(4), .GAP_CYCLES(2), .ACK_TIMEOUT(0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_rst_req(sw), .i_stage_ack(ack_a),
    .o_out_rst_n(out_a), .o_all_ready(rdy_a), .o_timeout(to_a));

  reset_sequencer #(.NUM_STAGES(3), .HOLD_CYCLES(2), .GAP_CYCLES(0), .ACK_TIMEOUT(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_rst_req(sw), .i_stage_ack(ack_b),
    .o_out_rst_n(out_b), .o_all_ready(rdy_b), .o_timeout(to_b));

  reset_sequencer #(.NUM_STAGES(3), .HOLD_CYCLES(4), .GAP_CYCLES(2), .ACK_TIMEOUT(5)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_rst_req(sw), .i_stage_ack(ack_c),
    .o_out_rst_n(out_c), .o_all_ready(rdy_c), .o_timeout(to_c));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_e = 0;
    for (int k = 0; k < 3; k++) begin
      m_rel[k] = 0; m_pend[k] = p_h[k]; m_since[k] = 0;
      m_wait[k] = 1'b0; m_rdy[k] = 1'b0; m_to[k] = 1'b0;
    end
  endtask

  task automatic model_release(input int k);
    m_rel_edge[k][m_rel[k]] = m_e;
    m_rel[k]++;
    m_since[k] = m_e;
    m_wait[k] = 1'b1;
  endtask

  task automatic model_edge(input int k, input logic s, input logic [2:0] a);
    logic ab;
    if (s) begin
      m_rel[k] = 0; m_pend[k] = m_e + p_h[k];
      m_wait[k] = 1'b0; m_rdy[k] = 1'b0; m_to[k] = 1'b0;
    end else if (m_wait[k]) begin
      ab = a[m_rel[k]-1];
      if (ab || (p_t[k] > 0 && (m_e - m_since[k]) == p_t[k])) begin
        if (!ab) m_to[k] = 1'b1;
        m_wait[k] = 1'b0;
        if (m_rel[k] == N) m_rdy[k] = 1'b1;
        else if (p_g[k] == 0) model_release(k);
        else m_pend[k] = m_e + p_g[k];
      end
    end else if (!m_rdy[k] && m_rel[k] < N && m_pend[k] == m_e) begin
      model_release(k);
    end
  endtask

  function automatic logic [4:0] exp_of(input int k);
    return {3'((1 << m_rel[k]) - 1), m_rdy[k], m_to[k]};
  endfunction

  // One clock: model absorbs the inputs seen at posedge, then returns at negedge.
  task automatic step();
    logic [2:0] a0, a1, a2;
    logic s;
    @(posedge clk);
    a0 = ack_a; a1 = ack_b; a2 = ack_c; s = sw;
    if (rst_n) begin
      m_e++;
      model_edge(0, s, a0);
      model_edge(1, s, a1);
      model_edge(2, s, a2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; sw = 1'b0; ack_a = '0; ack_b = '0; ack_c = '0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({d_out[k], d_rdy[k], d_to[k]} !== 5'b0) begin
        errors++; $display("FAIL reset_async dut%0d: got %b expected 00000", k, {d_out[k], d_rdy[k], d_to[k]});
      end
    end
    model_reset();
    ack_a = '1; ack_b = '1; ack_c = '1; sw = 1'b1;
    repeat (3) step();
    sw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({d_out[k], d_rdy[k], d_to[k]} !== 5'b0) begin
        errors++; $display("FAIL reset_held dut%0d: got %b expected 00000", k, {d_out[k], d_rdy[k], d_to[k]});
      end
    end
  endtask

  task automatic test_directed();
    int fa[4], fb[4], fc[4], fto;
    int ea[4] = '{4, 9, 14, 17};
    int eb[4] = '{2, 3, 4, 5};
    int ec[4] = '{4, 7, 14, 15};
    for (int i = 0; i < 4; i++) begin fa[i] = -1; fb[i] = -1; fc[i] = -1; end
    fto = -1;
    ack_a = 3'b000; ack_b = 3'b111; ack_c = 3'b101;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 24; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({d_out[k], d_rdy[k], d_to[k]} !== exp_of(k)) begin
          errors++; $display("FAIL directed dut%0d edge %0d: got %b expected %b", k, m_e, {d_out[k], d_rdy[k], d_to[k]}, exp_of(k));
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (out_a[i] && fa[i] < 0) fa[i] = m_e;
        if (out_b[i] && fb[i] < 0) fb[i] = m_e;
        if (out_c[i] && fc[i] < 0) fc[i] = m_e;
        if (i < m_rel[0] && m_e >= m_rel_edge[0][i] + 2) ack_a[i] = 1'b1;
      end
      if (rdy_a && fa[3] < 0) fa[3] = m_e;
      if (rdy_b && fb[3] < 0) fb[3] = m_e;
      if (rdy_c && fc[3] < 0) fc[3] = m_e;
      if (to_c && fto < 0) fto = m_e;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fa[i] != ea[i]) begin errors++; $display("FAIL seq_gap2 item%0d: rose at %0d expected %0d", i, fa[i], ea[i]); end
      checks++;
      if (fb[i] != eb[i]) begin errors++; $display("FAIL seq_gap0 item%0d: rose at %0d expected %0d", i, fb[i], eb[i]); end
      checks++;
      if (fc[i] != ec[i]) begin errors++; $display("FAIL seq_timeout item%0d: rose at %0d expected %0d", i, fc[i], ec[i]); end
    end
    checks++;
    if (fto != 12) begin errors++; $display("FAIL timeout_flag: rose at %0d expected 12", fto); end
  endtask

  task automatic test_sw_reset();
    int n;
    ack_a = '0; ack_b = '0; ack_c = '0;
    sw = 1'b1; step(); sw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({d_out[k], d_rdy[k], d_to[k]} !== exp_of(k)) begin
        errors++; $display("FAIL sw_clear dut%0d: got %b expected %b", k, {d_out[k], d_rdy[k], d_to[k]}, exp_of(k));
      end
    end
    n = 0;
    while (m_rel[0] == 0 && n < 20) begin step(); n++; end
    checks++;
    if (out_a !== 3'b001) begin errors++; $display("FAIL sw_first_release: got %b expected 001", out_a); end
    ack_a = 3'b001; sw = 1'b1; step(); sw = 1'b0;
    checks++;
    if ({out_a, rdy_a, to_a} !== 5'b0) begin errors++; $display("FAIL sw_priority: got %b expected 00000", {out_a, rdy_a, to_a}); end
    ack_a = 3'b111;
    n = 0;
    while (!m_rdy[0] && n < 40) begin
      step(); n++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({d_out[k], d_rdy[k], d_to[k]} !== exp_of(k)) begin
          errors++; $display("FAIL sw_rerun dut%0d edge %0d: got %b expected %b", k, m_e, {d_out[k], d_rdy[k], d_to[k]}, exp_of(k));
        end
      end
    end
    checks++;
    if (rdy_a !== 1'b1) begin errors++; $display("FAIL sw_rerun_ready: got %b expected 1", rdy_a); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      ack_a = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      ack_b = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      ack_c = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      sw    = ($urandom_range(0, 59) == 0);
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({d_out[k], d_rdy[k], d_to[k]} !== exp_of(k)) begin
          errors++; $display("FAIL random dut%0d edge %0d: got %b expected %b", k, m_e, {d_out[k], d_rdy[k], d_to[k]}, exp_of(k));
        end
      end
    end
    sw = 1'b0;
  endtask

  task automatic test_async_reset();
    int n, fr;
    ack_a = 3'b111; ack_b = '0; ack_c = '0;
    sw = 1'b1; step(); sw = 1'b0;
    n = 0;
    while (!(m_rel[0] >= 1 && !m_wait[0] && !m_rdy[0]) && n < 30) begin step(); n++; end
    checks++;
    if (out_a === 3'b000) begin errors++; $display("FAIL async_pre: got %b expected nonzero", out_a); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({d_out[k], d_rdy[k]} !== 4'b0) begin
        errors++; $display("FAIL async_clear dut%0d: got %b expected 0000", k, {d_out[k], d_rdy[k]});
      end
    end
    repeat (2) step();
    rst_n = 1'b1;
    fr = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_a[0] && fr < 0) fr = m_e;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({d_out[k], d_rdy[k], d_to[k]} !== exp_of(k)) begin
          errors++; $display("FAIL async_rerun dut%0d edge %0d: got %b expected %b", k, m_e, {d_out[k], d_rdy[k], d_to[k]}, exp_of(k));
        end
      end
    end
    checks++;
    if (fr != 4) begin errors++; $display("FAIL async_hold: stage0 rose at %0d expected 4", fr); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sw_reset();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
